// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 raster timing, so the cell renderer and the scan generator
// agree on every porch, sync window and total.
package vga_timing_pkg;

    localparam int VGA_CLK_DIV  = 2;
    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;

    localparam int VGA_H_TOTAL      = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
    localparam int VGA_V_TOTAL      = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;
    localparam int VGA_H_SYNC_START = VGA_H_ACTIVE + VGA_H_FP;
    localparam int VGA_H_SYNC_END   = VGA_H_SYNC_START + VGA_H_SYNC;
    localparam int VGA_V_SYNC_START = VGA_V_ACTIVE + VGA_V_FP;
    localparam int VGA_V_SYNC_END   = VGA_V_SYNC_START + VGA_V_SYNC;

    // True when lo <= pos < hi; used for both sync windows.
    function automatic logic inWindow(input logic [9:0] pos, input int lo, input int hi);
        return (int'(pos) >= lo) && (int'(pos) < hi);
    endfunction

endpackage

// File: rtl/scan_counter.sv
// Modulo-N counter with enable and carry-out; carry is high on the enabled
// count that wraps back to zero, so counters can be chained.
module scan_counter #(
    parameter int N = 800,
    parameter int W = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en_i,
    output logic [W-1:0] count_o,
    output logic         carry_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    assign carry_o = en_i && (count_q == W'(N - 1));
    assign count_o = count_q;

    always_comb begin
        count_d = count_q;
        if (en_i) begin
            count_d = carry_o ? '0 : count_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/vga_scan_gen.sv
// Raster timing generator: scan position for the renderer, one registered
// output stage for green and both syncs, and a vertical-blanking strobe.
module vga_scan_gen
    import vga_timing_pkg::*;
#(
    parameter int CLK_DIV     = VGA_CLK_DIV,
    parameter int H_ACTIVE    = VGA_H_ACTIVE,
    parameter int H_FP        = VGA_H_FP,
    parameter int H_SYNC      = VGA_H_SYNC,
    parameter int H_BP        = VGA_H_BP,
    parameter int V_ACTIVE    = VGA_V_ACTIVE,
    parameter int V_FP        = VGA_V_FP,
    parameter int V_SYNC      = VGA_V_SYNC,
    parameter int V_BP        = VGA_V_BP,
    parameter bit SYNC_ACTIVE = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pix_in,
    output logic [9:0] CounterX,
    output logic [8:0] CounterY,
    output logic       in_display,
    output logic       pix_tick,
    output logic       vblank_start,
    output logic       vga_hsync,
    output logic       vga_vsync,
    output logic       vga_g
);

    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = VS_START + V_SYNC;

    logic [9:0] hCount;
    logic [9:0] vCount;
    logic       hCarry;
    logic       unusedVCarry;
    logic       pixTick;

    // Pixel-rate divider; at CLK_DIV=1 every system clock is a pixel.
    generate
        if (CLK_DIV == 1) begin : gNoDiv
            assign pixTick = 1'b1;
        end else begin : gDiv
            logic [1:0] divCnt_q;
            logic [1:0] divCnt_d;

            assign pixTick  = (divCnt_q == 2'(CLK_DIV - 1));
            assign divCnt_d = pixTick ? 2'd0 : divCnt_q + 2'd1;

            always_ff @(posedge clk) begin
                if (rst) begin
                    divCnt_q <= 2'd0;
                end else begin
                    divCnt_q <= divCnt_d;
                end
            end
        end
    endgenerate

    scan_counter #(.N(H_TOTAL), .W(10)) uHCount (
        .clk     (clk),
        .rst     (rst),
        .en_i    (pixTick),
        .count_o (hCount),
        .carry_o (hCarry)
    );

    scan_counter #(.N(V_TOTAL), .W(10)) uVCount (
        .clk     (clk),
        .rst     (rst),
        .en_i    (hCarry),
        .count_o (vCount),
        .carry_o (unusedVCarry)
    );

    // Position is combinational so the renderer's pixel lands in the same cycle.
    assign CounterX     = hCount;
    assign CounterY     = vCount[8:0];
    assign in_display   = (hCount < 10'(H_ACTIVE)) && (vCount < 10'(V_ACTIVE));
    assign pix_tick     = pixTick;
    assign vblank_start = hCarry && (vCount == 10'(V_ACTIVE - 1));

    logic green_q, green_d;
    logic hsync_q, hsync_d;
    logic vsync_q, vsync_d;

    always_comb begin
        green_d = pix_in & in_display;
        hsync_d = inWindow(hCount, HS_START, HS_END) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        vsync_d = inWindow(vCount, VS_START, VS_END) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    end

    // Colour and syncs share one stage so they stay aligned at the pins.
    always_ff @(posedge clk) begin
        if (rst) begin
            green_q <= 1'b0;
            hsync_q <= ~SYNC_ACTIVE;
            vsync_q <= ~SYNC_ACTIVE;
        end else if (pixTick) begin
            green_q <= green_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
        end
    end

    assign vga_g     = green_q;
    assign vga_hsync = hsync_q;
    assign vga_vsync = vsync_q;

endmodule

// File: tb/tb_vga_scan_gen.sv
// Bench for vga_scan_gen: two shrunken-timing instances (CLK_DIV 2 and 1) and
// one full 640x480 instance, all checked every clock against an arithmetic model.
module tb_vga_scan_gen;

    localparam int NI = 3;

    typedef struct {
        int d, ha, hf, hs, hb, va, vf, vs, vb;
    } timing_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pix      [NI];
    logic [9:0] cx       [NI];
    logic [8:0] cy       [NI];
    logic       disp     [NI];
    logic       tick     [NI];
    logic       vbs      [NI];
    logic       hsO      [NI];
    logic       vsO      [NI];
    logic       gO       [NI];

    int checks = 0;
    int errors = 0;

    int   k        [NI];
    logic expG     [NI];
    logic expH     [NI];
    logic expV     [NI];
    logic modelPix [NI];

    int   cyc = 0;
    int   sinceRel = 0;
    int   firstTickAt [NI];
    int   vblankCount [NI];
    int   greenCount  [NI];
    int   lastFall, linePeriod, lowRun, hsWidth;
    logic prevHs;

    always #5 clk = ~clk;

    vga_scan_gen #(
        .CLK_DIV(2), .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
        .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1), .SYNC_ACTIVE(1'b0)
    ) dut0 (
        .clk(clk), .rst(rst), .pix_in(pix[0]), .CounterX(cx[0]), .CounterY(cy[0]),
        .in_display(disp[0]), .pix_tick(tick[0]), .vblank_start(vbs[0]),
        .vga_hsync(hsO[0]), .vga_vsync(vsO[0]), .vga_g(gO[0])
    );

    vga_scan_gen #(
        .CLK_DIV(1), .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
        .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1), .SYNC_ACTIVE(1'b0)
    ) dut1 (
        .clk(clk), .rst(rst), .pix_in(pix[1]), .CounterX(cx[1]), .CounterY(cy[1]),
        .in_display(disp[1]), .pix_tick(tick[1]), .vblank_start(vbs[1]),
        .vga_hsync(hsO[1]), .vga_vsync(vsO[1]), .vga_g(gO[1])
    );

    vga_scan_gen dut2 (
        .clk(clk), .rst(rst), .pix_in(pix[2]), .CounterX(cx[2]), .CounterY(cy[2]),
        .in_display(disp[2]), .pix_tick(tick[2]), .vblank_start(vbs[2]),
        .vga_hsync(hsO[2]), .vga_vsync(vsO[2]), .vga_g(gO[2])
    );

    function automatic timing_t tim(input int i);
        timing_t t;
        if (i == 2) t = '{2, 640, 16, 96, 48, 480, 10, 2, 33};
        else        t = '{(i == 0) ? 2 : 1, 16, 2, 4, 3, 6, 1, 2, 1};
        return t;
    endfunction

    // Pixel number within the frame is simply (clocks since reset / CLK_DIV) mod frame size.
    function automatic int pixelNum(input int i, input int kk);
        timing_t t = tim(i);
        int ht = t.ha + t.hf + t.hs + t.hb;
        int vt = t.va + t.vf + t.vs + t.vb;
        return (kk / t.d) % (ht * vt);
    endfunction

    function automatic int posH(input int i, input int kk);
        timing_t t = tim(i);
        return pixelNum(i, kk) % (t.ha + t.hf + t.hs + t.hb);
    endfunction

    function automatic int posV(input int i, input int kk);
        timing_t t = tim(i);
        return pixelNum(i, kk) / (t.ha + t.hf + t.hs + t.hb);
    endfunction

    function automatic logic dispAt(input int i, input int kk);
        timing_t t = tim(i);
        return (posH(i, kk) < t.ha) && (posV(i, kk) < t.va);
    endfunction

    function automatic logic hsAt(input int i, input int kk);
        timing_t t = tim(i);
        int h = posH(i, kk);
        return !((h >= t.ha + t.hf) && (h < t.ha + t.hf + t.hs));
    endfunction

    function automatic logic vsAt(input int i, input int kk);
        timing_t t = tim(i);
        int v = posV(i, kk);
        return !((v >= t.va + t.vf) && (v < t.va + t.vf + t.vs));
    endfunction

    function automatic logic tickAt(input int i, input int kk);
        timing_t t = tim(i);
        return (t.d == 1) || ((kk % t.d) == (t.d - 1));
    endfunction

    task automatic chk(input string tag, input int i, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s inst%0d k=%0d: observed %0h expected %0h", tag, i, k[i], obs, exp);
        end
    endtask

    task automatic checkOutput(input int i);
        timing_t t = tim(i);
        int  h = posH(i, k[i]);
        int  v = posV(i, k[i]);
        logic tk = tickAt(i, k[i]);
        chk("CounterX", i, 32'(cx[i]), 32'(h));
        chk("CounterY", i, 32'(cy[i]), 32'(v % 512));
        chk("in_display", i, 32'(disp[i]), 32'(dispAt(i, k[i])));
        chk("pix_tick", i, 32'(tick[i]), 32'(tk));
        chk("vblank_start", i, 32'(vbs[i]),
            32'(tk && (h == t.ha + t.hf + t.hs + t.hb - 1) && (v == t.va - 1)));
        chk("vga_hsync", i, 32'(hsO[i]), 32'(expH[i]));
        chk("vga_vsync", i, 32'(vsO[i]), 32'(expV[i]));
        chk("vga_g", i, 32'(gO[i]), 32'(expG[i]));
        if (cx[i] != 10'd0 && firstTickAt[i] < 0) firstTickAt[i] = sinceRel;
        if (vbs[i] === 1'b1) vblankCount[i]++;
        if (gO[i] === 1'b1) greenCount[i]++;
        if (i == 2) begin
            if (prevHs === 1'b1 && hsO[2] === 1'b0) begin
                if (lastFall >= 0) linePeriod = cyc - lastFall;
                lastFall = cyc;
            end
            if (hsO[2] === 1'b0) lowRun++;
            else if (lowRun > 0) begin
                hsWidth = lowRun;
                lowRun  = 0;
            end
            prevHs = hsO[2];
        end
    endtask

    // mode 0: random pixel, 1: pixel tied high, 2: renderer loop, 3: X during blanking
    task automatic applyStimulus(input int mode, input int rstPerMille);
        rst = ($urandom_range(0, 999) < rstPerMille);
        for (int i = 0; i < NI; i++) begin
            logic r = 1'($urandom_range(0, 1));
            case (mode)
                1: begin
                    pix[i] = 1'b1;
                    modelPix[i] = 1'b1;
                end
                2: begin
                    pix[i] = (cx[i] == 10'd5) && (cy[i] == 9'd0);
                    modelPix[i] = (posH(i, k[i]) == 5) && (posV(i, k[i]) == 0);
                end
                3: begin
                    pix[i] = dispAt(i, k[i]) ? r : 1'bx;
                    modelPix[i] = pix[i];
                end
                default: begin
                    pix[i] = r;
                    modelPix[i] = r;
                end
            endcase
        end
    endtask

    task automatic updateModel();
        if (rst) sinceRel = 0;
        else     sinceRel++;
        for (int i = 0; i < NI; i++) begin
            if (rst) begin
                k[i] = 0;
                expG[i] = 1'b0;
                expH[i] = 1'b1;
                expV[i] = 1'b1;
                firstTickAt[i] = -1;
            end else begin
                if (tickAt(i, k[i])) begin
                    expG[i] = modelPix[i] & dispAt(i, k[i]);
                    expH[i] = hsAt(i, k[i]);
                    expV[i] = vsAt(i, k[i]);
                end
                k[i]++;
            end
        end
    endtask

    task automatic runPhase(input int cycles, input int mode, input int rstPerMille);
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            cyc++;
            for (int i = 0; i < NI; i++) checkOutput(i);
            applyStimulus(mode, rstPerMille);
            updateModel();
        end
    endtask

    task automatic clearTrackers();
        for (int i = 0; i < NI; i++) begin
            vblankCount[i] = 0;
            greenCount[i]  = 0;
        end
        lastFall   = -1;
        linePeriod = -1;
        lowRun     = 0;
        hsWidth    = -1;
        prevHs     = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < NI; i++) begin
            pix[i] = 1'b0;
            modelPix[i] = 1'b0;
        end
        rst = 1'b1;
        repeat (3) @(posedge clk);
        updateModel();
        clearTrackers();

        // Reset held: every output at its reset value.
        runPhase(3, 0, 1000);

        // Line timing from release, with the pixel tied high.
        clearTrackers();
        runPhase(3300, 1, 0);
        chk("first_tick_clks", 0, 32'(firstTickAt[0]), 32'd2);
        chk("first_tick_clks", 1, 32'(firstTickAt[1]), 32'd1);
        chk("first_tick_clks", 2, 32'(firstTickAt[2]), 32'd2);
        chk("line_period_clks", 2, 32'(linePeriod), 32'd1600);
        chk("hsync_low_clks", 2, 32'(hsWidth), 32'd192);

        // Reset mid-frame, then three small frames with the renderer loop.
        runPhase(2, 0, 1000);
        clearTrackers();
        runPhase(1500, 2, 0);
        chk("vblank_pulses", 0, 32'(vblankCount[0]), 32'd3);
        chk("vblank_pulses", 1, 32'(vblankCount[1]), 32'd6);
        chk("renderer_green_clks", 0, 32'(greenCount[0]), 32'd6);
        chk("renderer_green_clks", 1, 32'(greenCount[1]), 32'd6);
        chk("renderer_green_clks", 2, 32'(greenCount[2]), 32'd2);

        // Random pixels with occasional resets, then X driven during blanking.
        runPhase(4000, 0, 3);
        runPhase(1500, 3, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
